// File: rtl/prism_shift_fifo.sv
// prism_shift_fifo: serial shift engine plus word FIFO between the PRISM strobes and the CPU.
//
// RX mode assembles DATA_W serial bits per word and queues each completed word for the CPU.
// TX mode takes CPU-written words from the FIFO and serialises them under PRISM shift strobes.
// When the next word is already queued, the TX side reloads it on the last bit with no gap bit.
//
// Ports:
//   clk_i, rst_n      clock, asynchronous active-low reset
//   exec_i, shift_i   PRISM executing / shift strobe (shift only acts while exec_i=1)
//   mode_tx_i         0 = RX, 1 = TX (change only together with flush_i)
//   lsb_first_i       bit order, 1 = LSB first
//   flush_i           synchronous clear of FIFO and shifter (sticky flags kept)
//   ser_in_i          RX serial data
//   ser_out_o         TX serial data, 1 when idle or in RX mode
//   bit_cnt_o         bits shifted in the current word
//   cpu_wr_i          push cpu_wdata_i (TX only)
//   cpu_wdata_i       push data
//   cpu_rd_i          pop head (RX only)
//   cpu_rdata_o       FIFO head, 0 when empty
//   fifo_level_o      entries held
//   fifo_full_o       FIFO full
//   fifo_empty_o      FIFO empty
//   thresh_i          watermark level
//   clr_flags_i       clear sticky flags
//   overflow_o        sticky: push attempted while full
//   underflow_o       sticky: pop while empty, or TX shift while idle
//   irq_o             watermark hit or overflow
module prism_shift_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1),
    localparam int unsigned CNT_W = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              exec_i,
    input  logic              shift_i,
    input  logic              mode_tx_i,
    input  logic              lsb_first_i,
    input  logic              flush_i,
    input  logic              ser_in_i,
    output logic              ser_out_o,
    output logic [CNT_W-1:0]  bit_cnt_o,
    input  logic              cpu_wr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_rd_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic              fifo_full_o,
    output logic              fifo_empty_o,
    input  logic [LVL_W-1:0]  thresh_i,
    input  logic              clr_flags_i,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              irq_o
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_busy_q, tx_busy_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              rx_shift, tx_shift, cnt_last;
    logic              empty, full;
    logic [DATA_W-1:0] head, rx_word, tx_shifted, push_data;
    logic              tx_load, pop_req, pop_ok, push_req, push_ok;
    logic              set_ovf, set_udf, watermark;

    always_comb begin
        rx_shift = exec_i & shift_i & ~mode_tx_i;
        tx_shift = exec_i & shift_i & mode_tx_i;
        cnt_last = (bit_cnt_q == CntLast);
        empty    = (level_q == '0);
        full     = (level_q == LvlFull);
        head     = mem_q[rd_ptr_q];

        rx_word    = lsb_first_i ? {ser_in_i, sreg_q[DATA_W-1:1]}
                                 : {sreg_q[DATA_W-2:0], ser_in_i};
        tx_shifted = lsb_first_i ? {1'b1, sreg_q[DATA_W-1:1]}
                                 : {sreg_q[DATA_W-2:0], 1'b1};

        // TX pulls a word either from idle or on the last bit of the current word (seamless).
        tx_load  = mode_tx_i & exec_i & ~empty & (~tx_busy_q | (tx_shift & cnt_last));
        pop_req  = mode_tx_i ? tx_load : cpu_rd_i;
        pop_ok   = pop_req & ~empty;
        push_req = mode_tx_i ? cpu_wr_i : (rx_shift & cnt_last);
        push_data = mode_tx_i ? cpu_wdata_i : rx_word;
        // A pop in the same cycle frees the slot a push needs when full.
        push_ok  = push_req & (~full | pop_ok);

        set_ovf = ~flush_i & push_req & ~push_ok;
        set_udf = ~flush_i & ((~mode_tx_i & cpu_rd_i & empty) | (tx_shift & ~tx_busy_q));
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_busy_d = tx_busy_q;

        if (flush_i) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            level_d   = '0;
            sreg_d    = '0;
            bit_cnt_d = '0;
            tx_busy_d = 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

            if (!mode_tx_i) begin
                if (rx_shift) begin
                    sreg_d    = rx_word;
                    bit_cnt_d = cnt_last ? '0 : bit_cnt_q + CNT_W'(1);
                end
            end else if (tx_load) begin
                sreg_d    = head;
                bit_cnt_d = '0;
                tx_busy_d = 1'b1;
            end else if (tx_busy_q && tx_shift) begin
                sreg_d = tx_shifted;
                if (cnt_last) begin
                    bit_cnt_d = '0;
                    tx_busy_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        // Setting a sticky flag wins over clearing it in the same cycle.
        ovf_d = (ovf_q & ~clr_flags_i) | set_ovf;
        udf_d = (udf_q & ~clr_flags_i) | set_udf;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            tx_busy_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_busy_q <= tx_busy_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        watermark    = mode_tx_i ? (level_q <= thresh_i) : (level_q >= thresh_i);
        irq_o        = ovf_q | watermark;
        ser_out_o    = (mode_tx_i && tx_busy_q) ? (lsb_first_i ? sreg_q[0] : sreg_q[DATA_W-1])
                                                : 1'b1;
        bit_cnt_o    = bit_cnt_q;
        cpu_rdata_o  = empty ? '0 : head;
        fifo_level_o = level_q;
        fifo_full_o  = full;
        fifo_empty_o = empty;
        overflow_o   = ovf_q;
        underflow_o  = udf_q;
    end

endmodule
